// File: rtl/xoroshiro_sched.sv
// xoroshiro_sched
// Pulls 64-bit words from a xoroshiro128 core and hands them out one byte at a
// time, most significant byte first, to NREQ requesters under round-robin
// arbitration.
// Optional feature: define XOROSHIRO_SCHED_RESEED_EN to enable the reseed path
// (SEED state, reseed input, gen_seed pulse). Without it, reseed is ignored
// and gen_seed is tied low.
module xoroshiro_sched #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [7:0]      rdata,
  output logic            rvalid,
  output logic            gen_step,
  output logic            gen_seed,
  input  logic            gen_ready,
  input  logic [63:0]     gen_word,
  input  logic            reseed
);

  localparam int PW = $clog2(NREQ);

`ifdef XOROSHIRO_SCHED_RESEED_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SERVE = 2'd2,
    SEED  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SERVE = 2'd2
  } state_t;
`endif

  state_t          state_r;
  state_t          state_n_s;
  logic [63:0]     buffer_r;
  logic [2:0]      index_r;
  logic [PW-1:0]   ptr_r;
  logic [NREQ-1:0] gnt_r;
  logic [7:0]      rdata_r;
  logic            rvalid_r;
  logic            gen_step_r;

  logic            step_n_s;
  logic            grant_s;
  logic            load_s;
  logic            discard_s;
  logic            any_s;
  logic [PW-1:0]   win_s;
  logic [PW-1:0]   ptr_nx_s;
  logic [NREQ-1:0] win_oh_s;
  logic [2:0]      sel_s;
  logic [7:0]      byte_s;
  int              dist_s;
  int              best_d_s;

`ifdef XOROSHIRO_SCHED_RESEED_EN
  logic            reseed_q_r;
  logic            pend_r;
  logic            gen_seed_r;
  logic            rise_s;
  logic            seed_n_s;
  logic            pend_set_s;
  logic            pend_clr_s;

  // Only a rising level of reseed starts a reseed pass.
  assign rise_s = reseed & ~reseed_q_r;
`else
  logic            unused_s;

  assign unused_s = reseed;
`endif

  // Byte index 0 is the most significant byte of the buffered word.
  assign sel_s    = 3'd7 - index_r;
  assign byte_s   = buffer_r[{sel_s, 3'b000} +: 8];
  assign win_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
  assign ptr_nx_s = (win_s == PW'(NREQ - 1)) ? {PW{1'b0}} : (win_s + PW'(1));

  // Round-robin pick: the requester closest at or after the pointer wins.
  always_comb begin
    win_s    = {PW{1'b0}};
    any_s    = 1'b0;
    best_d_s = NREQ;
    dist_s   = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (i >= int'(ptr_r)) begin
        dist_s = i - int'(ptr_r);
      end else begin
        dist_s = i + NREQ - int'(ptr_r);
      end
      if (req[i] && (dist_s < best_d_s)) begin
        best_d_s = dist_s;
        win_s    = PW'(i);
        any_s    = 1'b1;
      end else begin
        best_d_s = best_d_s;
      end
    end
  end

  // Next-state and one-cycle command decode.
  always_comb begin
    state_n_s  = state_r;
    step_n_s   = 1'b0;
    grant_s    = 1'b0;
    load_s     = 1'b0;
    discard_s  = 1'b0;
`ifdef XOROSHIRO_SCHED_RESEED_EN
    seed_n_s   = 1'b0;
    pend_set_s = 1'b0;
    pend_clr_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
`ifdef XOROSHIRO_SCHED_RESEED_EN
        if (rise_s) begin
          state_n_s = SEED;
          seed_n_s  = 1'b1;
          discard_s = 1'b1;
        end else begin
          state_n_s = FETCH;
          step_n_s  = 1'b1;
        end
`else
        state_n_s = FETCH;
        step_n_s  = 1'b1;
`endif
      end
      FETCH: begin
        if (gen_ready) begin
`ifdef XOROSHIRO_SCHED_RESEED_EN
          // A reseed seen while waiting turns this word into a throwaway.
          if (pend_r || rise_s) begin
            state_n_s  = SEED;
            seed_n_s   = 1'b1;
            pend_clr_s = 1'b1;
            discard_s  = 1'b1;
          end else begin
            state_n_s = SERVE;
            load_s    = 1'b1;
          end
`else
          state_n_s = SERVE;
          load_s    = 1'b1;
`endif
        end else begin
`ifdef XOROSHIRO_SCHED_RESEED_EN
          pend_set_s = rise_s;
`else
          state_n_s = FETCH;
`endif
        end
      end
      SERVE: begin
`ifdef XOROSHIRO_SCHED_RESEED_EN
        // Reseed takes priority over any pending request this cycle.
        if (rise_s) begin
          state_n_s = SEED;
          seed_n_s  = 1'b1;
          discard_s = 1'b1;
        end else
`endif
        if (any_s) begin
          grant_s = 1'b1;
          if (index_r == 3'd7) begin
            state_n_s = FETCH;
            step_n_s  = 1'b1;
          end else begin
            state_n_s = SERVE;
          end
        end else begin
          state_n_s = SERVE;
        end
      end
`ifdef XOROSHIRO_SCHED_RESEED_EN
      SEED: begin
        if (gen_ready) begin
          state_n_s = FETCH;
          step_n_s  = 1'b1;
        end else begin
          state_n_s = SEED;
        end
      end
`endif
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State, word buffer, byte index, arbitration pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      buffer_r   <= 64'd0;
      index_r    <= 3'd0;
      ptr_r      <= {PW{1'b0}};
      gnt_r      <= {NREQ{1'b0}};
      rdata_r    <= 8'h00;
      rvalid_r   <= 1'b0;
      gen_step_r <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      gen_step_r <= step_n_s;
      rvalid_r   <= grant_s;
      if (grant_s) begin
        gnt_r   <= win_oh_s;
        rdata_r <= byte_s;
        index_r <= index_r + 3'd1;
        ptr_r   <= ptr_nx_s;
      end else begin
        gnt_r <= {NREQ{1'b0}};
        if (load_s || discard_s) begin
          buffer_r <= load_s ? gen_word : 64'd0;
          index_r  <= 3'd0;
        end else begin
          buffer_r <= buffer_r;
        end
      end
    end
  end

`ifdef XOROSHIRO_SCHED_RESEED_EN
  // Reseed edge history, pending-reseed flag and seed command pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reseed_q_r <= 1'b0;
      pend_r     <= 1'b0;
      gen_seed_r <= 1'b0;
    end else begin
      reseed_q_r <= reseed;
      gen_seed_r <= seed_n_s;
      if (pend_clr_s) begin
        pend_r <= 1'b0;
      end else if (pend_set_s) begin
        pend_r <= 1'b1;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

  assign gen_seed = gen_seed_r;
`else
  assign gen_seed = 1'b0;
`endif

  assign gnt      = gnt_r;
  assign rdata    = rdata_r;
  assign rvalid   = rvalid_r;
  assign gen_step = gen_step_r;

endmodule

// File: tb/tb_xoroshiro_sched.sv
// Testbench for xoroshiro_sched: a generator model answers step/seed pulses,
// pushes the bytes each served word should produce into a queue, and a
// monitor checks every delivered byte and grant against a round-robin model.
`timescale 1ns/1ps
module tb_xoroshiro_sched;
  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [7:0]      rdata;
  logic            rvalid;
  logic            gen_step;
  logic            gen_seed;
  logic            gen_ready;
  logic [63:0]     gen_word;
  logic            reseed;

  logic            gr_gen;
  logic            gr_stale;
  logic [63:0]     gw_gen;
  logic [63:0]     stale_word;

  assign gen_ready = gr_gen | gr_stale;
  assign gen_word  = gr_stale ? stale_word : gw_gen;

  xoroshiro_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .gen_step  (gen_step),
    .gen_seed  (gen_seed),
    .gen_ready (gen_ready),
    .gen_word  (gen_word),
    .reseed    (reseed)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  int          rv_cnt = 0;
  int          steps_seen = 0;
  int          seeds_seen = 0;
  logic        force_en = 1'b0;
  logic [63:0] force_word = 64'd0;
  int          force_lat = 1;
  logic        discard_next = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic wait_rv(input int n, input int budget, input string name);
    int target = rv_cnt + n;
    int k = 0;
    while (rv_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (rv_cnt < target) begin
      errors++;
      $display("FAIL %s: got %0d bytes, expected %0d within %0d cycles", name, rv_cnt - (target - n), n, budget);
    end
  endtask

  task automatic wait_partial(input int lo, input int hi, input string name);
    int k = 0;
    while (!(exp_q.size() >= lo && exp_q.size() <= hi) && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!(exp_q.size() >= lo && exp_q.size() <= hi)) begin
      errors++;
      $display("FAIL %s: got %0d queued bytes, expected %0d..%0d", name, exp_q.size(), lo, hi);
    end
  endtask

  // Generator model: answers step/seed after 1..4 cycles; served words feed the queue.
  initial begin : generator
    int          cnt;
    logic        is_seed;
    logic [63:0] w;
    cnt = 0;
    is_seed = 1'b0;
    gr_gen = 1'b0;
    gw_gen = 64'd0;
    forever begin
      @(posedge clk);
      #1;
      gr_gen = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            gr_gen = 1'b1;
            if (is_seed) begin
              gw_gen = {$urandom, $urandom};
            end else begin
              w = force_en ? force_word : {$urandom, $urandom};
              force_en = 1'b0;
              gw_gen = w;
              if (discard_next) discard_next = 1'b0;
              else for (int b = 7; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
            end
          end
        end
        if (gen_step || gen_seed) begin
          if (gen_step) steps_seen++;
          is_seed = gen_seed;
          cnt = (gen_step && force_en) ? force_lat : int'($urandom_range(1, 4));
        end
      end
    end
  end

  // Monitor: checks each delivered byte and its grant against the models.
  initial begin : monitor
    logic [NREQ-1:0] req_smp;
    logic [NREQ-1:0] exp_g;
    logic [7:0]      exp_b;
    int              ptr_m;
    int              nxt;
    int              c;
    ptr_m = 0;
    forever begin
      @(posedge clk);
      req_smp = req;
      #1;
      if (!rst_n) begin
        ptr_m = 0;
      end else begin
        if (gen_seed) seeds_seen++;
        if (rvalid) begin
          rv_cnt++;
          exp_g = '0;
          nxt = ptr_m;
          for (int k = 0; k < NREQ; k++) begin
            c = (ptr_m + k) % NREQ;
            if (exp_g == '0 && req_smp[c]) begin
              exp_g[c] = 1'b1;
              nxt = (c + 1) % NREQ;
            end
          end
          ptr_m = nxt;
          check("gnt", 64'(gnt), 64'(exp_g));
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rdata: got unexpected byte %0h, expected none", rdata);
          end else begin
            exp_b = exp_q.pop_front();
            check("rdata", 64'(rdata), 64'(exp_b));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s0;
    int seeds0;
    int k;
    req = '0;
    reseed = 1'b0;
    gr_stale = 1'b0;
    stale_word = 64'hDEAD_BEEF_0BAD_F00D;
    force_en = 1'b1;
    force_word = 64'h0123_4567_89AB_CDEF;
    force_lat = 2;
    repeat (3) @(negedge clk);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_step", 64'(gen_step), 64'd0);
    check("rst_seed", 64'(gen_seed), 64'd0);

    // Known word, single requester: bytes MSB first, then a new step.
    rst_n = 1'b1;
    req = 4'b0001;
    wait_rv(8, 60, "t1_bytes");
    check("t1_step", 64'(gen_step), 64'd1);

    // All requesters: rotation with pointer wrap.
    req = 4'b1111;
    wait_rv(10, 80, "t2_rr");
    // Sparse requesters.
    req = 4'b0101;
    wait_rv(6, 80, "t3_sparse");

    // Random request patterns including idle cycles.
    s0 = rv_cnt;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = '0;
      else req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
    end
    checks++;
    if (rv_cnt - s0 < 40) begin
      errors++;
      $display("FAIL t4_progress: got %0d bytes, expected at least 40", rv_cnt - s0);
    end

    // Reseed rising while a fetch is outstanding.
    req = 4'b1111;
    wait_partial(1, 7, "t5_serve");
    force_word = 64'hFFFF_FFFF_FFFF_FFFF;
    force_lat = 3;
    force_en = 1'b1;
`ifdef XOROSHIRO_SCHED_RESEED_EN
    discard_next = 1'b1;
`endif
    seeds0 = seeds_seen;
    s0 = steps_seen;
    k = 0;
    while (steps_seen == s0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t5_step_seen", 64'(steps_seen != s0), 64'd1);
    reseed = 1'b1;
    repeat (30) @(negedge clk);
`ifdef XOROSHIRO_SCHED_RESEED_EN
    check("t5_seed_count", 64'(seeds_seen - seeds0), 64'd1);
`else
    check("t5_seed_count", 64'(seeds_seen - seeds0), 64'd0);
`endif
    reseed = 1'b0;
    wait_rv(8, 80, "t5_after");

    // Reseed rising in the middle of a served word with requests pending.
    wait_partial(1, 7, "t6_serve");
    seeds0 = seeds_seen;
    reseed = 1'b1;
`ifdef XOROSHIRO_SCHED_RESEED_EN
    exp_q.delete();
    @(posedge clk);
    #1;
    check("t6_no_grant", 64'(rvalid), 64'd0);
    check("t6_seed", 64'(gen_seed), 64'd1);
`endif
    repeat (10) @(negedge clk);
    reseed = 1'b0;
    wait_rv(8, 80, "t6_after");

    // Reset after three bytes of a word; stale ready right after release.
    wait_partial(5, 5, "t7_three");
    rst_n = 1'b0;
    #1;
    check("t7_rvalid", 64'(rvalid), 64'd0);
    check("t7_gnt", 64'(gnt), 64'd0);
    check("t7_rdata", 64'(rdata), 64'd0);
    check("t7_step", 64'(gen_step), 64'd0);
    check("t7_seed", 64'(gen_seed), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gr_stale = 1'b1;
    @(posedge clk);
    #1;
    gr_stale = 1'b0;
    check("t7_fresh_step", 64'(gen_step), 64'd1);
    check("t7_no_rvalid", 64'(rvalid), 64'd0);
    wait_rv(8, 80, "t7_after");

`ifndef XOROSHIRO_SCHED_RESEED_EN
    check("seed_never", 64'(seeds_seen), 64'd0);
`endif
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
